// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate operations.
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_t;

  state_t      state_q;
  acc_t        acc_q;
  logic [3:0]  count_q;
  logic [63:0] pending_q;
  logic [31:0] hi_q, lo_q;

  logic        is_mul_d, is_div_d;
  acc_t        acc_d;
  logic [63:0] prod_s_d, prod_u_d, mul_res_d;
  logic        div_signed_d, neg_a_d, neg_b_d;
  logic [31:0] mag_a_d, mag_b_d, uq_d, ur_d, quot_d, rem_d;
  logic [63:0] div_res_d, done_d;

  // Decode and datapath, all evaluated on the issue-cycle operands.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_mul_d  = 1'b0;
    is_div_d  = 1'b0;
    acc_d     = ACC_SET;
    prod_s_d  = $signed({{32{SA[31]}}, SA}) * $signed({{32{SB[31]}}, SB});
    prod_u_d  = {32'b0, SA} * {32'b0, SB};
    mul_res_d = prod_s_d;
    unique case (MDUOp)
      OP_MULT:  is_mul_d = 1'b1;
      OP_MULTU: begin is_mul_d = 1'b1; mul_res_d = prod_u_d; end
      OP_DIV,
      OP_DIVU:  is_div_d = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul_d = 1'b1; acc_d = ACC_ADD; end
      OP_MADDU: begin is_mul_d = 1'b1; acc_d = ACC_ADD; mul_res_d = prod_u_d; end
      OP_MSUB:  begin is_mul_d = 1'b1; acc_d = ACC_SUB; end
      OP_MSUBU: begin is_mul_d = 1'b1; acc_d = ACC_SUB; mul_res_d = prod_u_d; end
`endif
      default: ;
    endcase

    // One unsigned divider serves both flavours; signed ops work on magnitudes.
    // Negating |0x8000_0000| / 1 gives back 0x8000_0000, covering the overflow case.
    div_signed_d = (MDUOp == OP_DIV);
    neg_a_d      = div_signed_d & SA[31];
    neg_b_d      = div_signed_d & SB[31];
    mag_a_d      = neg_a_d ? (~SA + 32'd1) : SA;
    mag_b_d      = neg_b_d ? (~SB + 32'd1) : SB;
    uq_d         = 32'd0;
    ur_d         = 32'd0;
    if (mag_b_d != 32'd0) begin
      uq_d = mag_a_d / mag_b_d;
      ur_d = mag_a_d % mag_b_d;
    end
    quot_d = (neg_a_d ^ neg_b_d) ? (~uq_d + 32'd1) : uq_d;
    rem_d  = neg_a_d ? (~ur_d + 32'd1) : ur_d;
    if (SB == 32'd0) div_res_d = {SA, 32'hFFFF_FFFF};
    else             div_res_d = {rem_d, quot_d};

    // Accumulating ops read HI/LO as they stand at the completion edge.
    unique case (acc_q)
      ACC_ADD: done_d = {hi_q, lo_q} + pending_q;
      ACC_SUB: done_d = {hi_q, lo_q} - pending_q;
      default: done_d = pending_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= ACC_SET;
      count_q   <= 4'd0;
      pending_q <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul_d) begin
              state_q   <= S_MUL;
              count_q   <= 4'(MUL_CYCLES);
              pending_q <= mul_res_d;
              acc_q     <= acc_d;
            end else if (is_div_d) begin
              state_q   <= S_DIV;
              count_q   <= 4'(DIV_CYCLES);
              pending_q <= div_res_d;
              acc_q     <= ACC_SET;
            end else if (MDUOp == OP_MTHI) begin
              hi_q <= SA;
            end else if (MDUOp == OP_MTLO) begin
              lo_q <= SA;
            end
          end
        end
        default: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_q      <= S_IDLE;
            {hi_q, lo_q} <= done_d;
          end
        end
      endcase
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy | (start & (is_mul_d | is_div_d));
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
